sc_schedule_ctrl: RTL
=====================

# sc_schedule_ctrl

Successive-cancellation schedule controller for the polar decoder datapath. It walks the SC decoding tree for an N = 2^LOG_N code and issues F, G and LEAF operations, one per handshake, to the shared processing-element array built from the magnitude-compare and sign-processing units. Operations wider than the PE array are split into chunks of P pairs. It sits between the top-level frame control and the PE array and has no LLR or data path of its own.

## Interface
- LOG_N, 3, log2 of code length N (2..10)
- LOG_P, 2, log2 of PE count P (0..LOG_N-1)
- FROZEN, 8'b0001_0111, N-bit frozen mask; bit i = 1 means u_i is frozen
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  frame start pulse; sampled only in IDLE
- op_ready  input  1  PE array accepts the current op
- op_valid  output  1  op fields valid
- op_type  output  2  0 = F, 1 = G, 2 = LEAF (3 is never issued)
- op_stage  output  clog2(LOG_N)  tree stage s of the op; 0 for LEAF
- op_chunk  output  LOG_N  chunk index within the node, 0..C(s)-1
- op_leaf  output  LOG_N  current leaf index i
- op_frozen  output  1  FROZEN[i]; meaningful on LEAF only, 0 otherwise
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame end
- stall_cnt  output  16  stall counter (see Configuration)

## Operation
- States: IDLE, F, G, LEAF, DONE.
- IDLE: start=1 -> F with stage = LOG_N-1, chunk = 0, leaf = 0, busy = 1.
- Chunk count per op at stage s: C(s) = max(1, 2^s / P). An F or G op advances chunk on each handshake; the op is complete on the handshake with chunk = C(s)-1.
- F complete: stage > 0 -> F at stage-1. stage = 0 -> LEAF.
- LEAF handshake with i < N-1: t = number of trailing ones of i. Next is G at stage t, chunk 0, leaf = i+1.
- LEAF handshake with i = N-1 -> DONE.
- G complete: stage > 0 -> F at stage-1. stage = 0 -> LEAF.
- DONE: done = 1 and busy = 0 for one cycle, then IDLE.
- Totals per frame: N-1 F nodes, N-1 G nodes, N LEAF ops. Each F and G node issues C(s) ops.
- start is ignored while busy.
- The frozen mask does not change the schedule. The datapath uses op_frozen to force u_i = 0.

## Timing
- Reset values: op_valid = 0, op_type = 0, op_stage = 0, op_chunk = 0, op_leaf = 0, op_frozen = 0, busy = 0, done = 0, stall_cnt = 0, state = IDLE.
- All outputs are registered.
- busy and op_valid rise on the cycle after start is sampled.
- Handshake: transfer when op_valid & op_ready.
  - While op_valid = 1 and op_ready = 0, all op_* fields are held stable.
  - op_valid stays 1 between ops, so one op is issued per cycle when op_ready = 1.
- done pulses on the cycle after the final LEAF handshake. op_valid is 0 in DONE.
- A start asserted in the DONE cycle is ignored. A start asserted in the next cycle (IDLE) is accepted.
- rst_n low at any point aborts immediately to the reset values. No done pulse is generated.

## Configuration
- SCHED_STALL_CNT_EN defined:
  - stall_cnt increments on every cycle with op_valid = 1 and op_ready = 0.
  - It saturates at 16'hFFFF and clears on start acceptance.
- SCHED_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter logic exists. The port list is unchanged.

## Structure
- Package sc_sched_pkg holds:
  - the op-type enum (OP_F, OP_G, OP_LEAF);
  - the state enum;
  - the chunk-count function C(s).
- Sub-module trailing_ones: combinational, LOG_N-bit input, returns the count of trailing ones. It computes the G stage after each leaf.

## Test plan
- Default parameters, op_ready = 1, start pulse at cycle 0:
  - ops on cycles 1..22 in the order F2 F1 F0 L0 G0 L1 G1 F0 L2 G0 L3 G2 F1 F0 L4 G0 L5 G1 F0 L6 G0 L7;
  - done on cycle 23 and busy low from cycle 23.
- LOG_P = 1, op_ready = 1:
  - F2 and G2 each issue chunks 0 and 1;
  - 24 ops in total;
  - done on cycle 25.
- op_ready toggled 0/1 pseudo-randomly:
  - the op sequence is identical to the first scenario;
  - fields stay stable during stalls;
  - with SCHED_STALL_CNT_EN defined, stall_cnt equals the number of op_ready = 0 cycles seen while op_valid = 1.
- Frozen mask check:
  - the LEAF ops for i = 0, 1, 2 and 4 carry op_frozen = 1;
  - the LEAF ops for i = 3, 5, 6 and 7 carry op_frozen = 0;
  - F and G ops carry op_frozen = 0.
- start re-asserted mid-frame at cycle 5: no effect on the sequence or counters. start asserted in the DONE cycle: ignored. start one cycle later: accepted.
- rst_n pulled low at cycle 10:
  - all outputs take their reset values asynchronously;
  - no done pulse;
  - a later start yields the full 22-op sequence.

Source files
------------

// File: rtl/sc_schedule_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sc_sched_pkg
// Shared types and helpers for the successive-cancellation schedule controller:
//   op_type_e    - operation issued to the PE array (F, G, LEAF)
//   state_e      - controller state encoding
//   chunk_count  - number of P-wide chunks an F/G node at stage s needs
// -----------------------------------------------------------------------------
package sc_sched_pkg;

  typedef enum logic [1:0] {
    OP_F    = 2'd0,
    OP_G    = 2'd1,
    OP_LEAF = 2'd2
  } op_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F,
    ST_G,
    ST_LEAF,
    ST_DONE
  } state_e;

  // C(s) = max(1, 2^s / 2^log_p)
  function automatic int unsigned chunk_count(input int unsigned s,
                                              input int unsigned log_p);
    if (s > log_p) return 32'd1 << (s - log_p);
    return 32'd1;
  endfunction

endpackage

// File: rtl/sc_schedule_ctrl_if.sv
// -----------------------------------------------------------------------------
// sc_schedule_ctrl_if
// Operation handshake between the schedule controller (master) and the PE
// array (slave).
//   op_valid  - op fields valid (master)
//   op_ready  - PE array accepts current op (slave)
//   op_type   - F / G / LEAF
//   op_stage  - tree stage of the op, 0 for LEAF
//   op_chunk  - chunk index within the node
//   op_leaf   - current leaf index
//   op_frozen - frozen flag of the current leaf, LEAF ops only
// -----------------------------------------------------------------------------
interface sc_schedule_ctrl_if
  import sc_sched_pkg::*;
#(
  parameter int unsigned LOG_N = 3
) ();

  localparam int unsigned SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  logic             op_valid;
  logic             op_ready;
  op_type_e         op_type;
  logic [SW-1:0]    op_stage;
  logic [LOG_N-1:0] op_chunk;
  logic [LOG_N-1:0] op_leaf;
  logic             op_frozen;

  modport master (
    output op_valid, op_type, op_stage, op_chunk, op_leaf, op_frozen,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_type, op_stage, op_chunk, op_leaf, op_frozen,
    output op_ready
  );

endinterface

// File: rtl/sc_schedule_ctrl_trailing_ones.sv
// -----------------------------------------------------------------------------
// trailing_ones
// Combinational count of consecutive 1 bits starting at bit 0.
//   val_i   - W-bit input word
//   count_o - number of trailing ones (0..W)
// -----------------------------------------------------------------------------
module trailing_ones #(
  parameter int unsigned W  = 3,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  val_i,
  output logic [CW-1:0] count_o
);

  logic run;

  always_comb begin
    count_o = '0;
    run     = 1'b1;
    for (int unsigned b = 0; b < W; b++) begin
      if (run && val_i[b]) count_o = count_o + CW'(1);
      else                 run     = 1'b0;
    end
  end

endmodule

// File: rtl/sc_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// sc_schedule_ctrl
// Successive-cancellation schedule controller. Walks the SC decoding tree of
// an N = 2^LOG_N polar code and issues F, G and LEAF ops one per handshake to
// the PE array; F/G ops wider than P = 2^LOG_P pairs are split into chunks.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - frame start pulse, sampled only in IDLE
//   op         - op handshake (master modport of sc_schedule_ctrl_if)
//   busy       - frame in progress
//   done       - one-cycle pulse at frame end
//   stall_cnt  - cycles with op_valid & !op_ready since last start
//
// Configuration macro:
//   SCHED_STALL_CNT_EN - when defined, stall_cnt is a saturating counter;
//                        otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module sc_schedule_ctrl
  import sc_sched_pkg::*;
#(
  parameter int unsigned                LOG_N  = 3,
  parameter int unsigned                LOG_P  = 2,
  parameter logic [(1 << LOG_N)-1:0]    FROZEN = 8'b0001_0111
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  sc_schedule_ctrl_if.master      op,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             stall_cnt
);

  localparam int unsigned SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int unsigned TW = $clog2(LOG_N + 1);

  state_e           state_q;
  op_type_e         type_q;
  logic [SW-1:0]    stage_q;
  logic [LOG_N-1:0] chunk_q;
  logic [LOG_N-1:0] leaf_q;
  logic             valid_q;
  logic             frozen_q;
  logic             busy_q;
  logic             done_q;

  logic             hs;
  logic             last_chunk;
  logic [TW-1:0]    tones;
  logic [SW-1:0]    g_stage;

  assign hs         = valid_q & op.op_ready;
  assign last_chunk = (chunk_q == LOG_N'(chunk_count(32'(stage_q), LOG_P) - 1));

  // After leaf i the walk climbs past every right child on the path, i.e.
  // one level per trailing 1 of i; the next G sits at that level.
  trailing_ones #(
    .W  (LOG_N),
    .CW (TW)
  ) u_tones (
    .val_i   (leaf_q),
    .count_o (tones)
  );

  assign g_stage = tones[SW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      type_q   <= OP_F;
      stage_q  <= '0;
      chunk_q  <= '0;
      leaf_q   <= '0;
      valid_q  <= 1'b0;
      frozen_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_F;
            type_q   <= OP_F;
            stage_q  <= SW'(LOG_N - 1);
            chunk_q  <= '0;
            leaf_q   <= '0;
            frozen_q <= 1'b0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_F, ST_G: begin
          if (hs) begin
            if (!last_chunk) begin
              chunk_q <= chunk_q + LOG_N'(1);
            end else begin
              chunk_q <= '0;
              if (stage_q != '0) begin
                state_q <= ST_F;
                type_q  <= OP_F;
                stage_q <= stage_q - SW'(1);
              end else begin
                state_q  <= ST_LEAF;
                type_q   <= OP_LEAF;
                frozen_q <= FROZEN[leaf_q];
              end
            end
          end
        end
        ST_LEAF: begin
          if (hs) begin
            frozen_q <= 1'b0;
            if (leaf_q == '1) begin
              state_q <= ST_DONE;
              type_q  <= OP_F;
              stage_q <= '0;
              chunk_q <= '0;
              leaf_q  <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_G;
              type_q  <= OP_G;
              stage_q <= g_stage;
              chunk_q <= '0;
              leaf_q  <= leaf_q + LOG_N'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign op.op_valid  = valid_q;
  assign op.op_type   = type_q;
  assign op.op_stage  = stage_q;
  assign op.op_chunk  = chunk_q;
  assign op.op_leaf   = leaf_q;
  assign op.op_frozen = frozen_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start)
      stall_d = '0;
    else if (valid_q && !op.op_ready && stall_q != '1)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
